// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the switch/button bank and the sequenced ALU front end.
// There is no valid/ready handshake on this bus. The three buttons are
// asynchronous level inputs that the slave synchronises and edge-detects.
// o_valid is a level that qualifies o_result and the flags. It rises when an
// operation completes. It drops when the next operand A is accepted.
interface alu_seq_ctrl_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] i_dato;
  logic               i_btn_a;
  logic               i_btn_b;
  logic               i_btn_op;
  logic [NB_DATA-1:0] o_result;
  logic               o_zero;
  logic               o_carry;
  logic               o_overflow;
  logic               o_err;
  logic               o_valid;
  logic [1:0]         o_state;

  modport master (
    output i_dato, i_btn_a, i_btn_b, i_btn_op,
    input  o_result, o_zero, o_carry, o_overflow, o_err, o_valid, o_state
  );

  modport slave (
    input  i_dato, i_btn_a, i_btn_b, i_btn_op,
    output o_result, o_zero, o_carry, o_overflow, o_err, o_valid, o_state
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU front end. Operand A, operand B and the opcode are loaded
// from one shared switch bus on three debounced button strobes. The block
// then executes once and holds the result and flags for the LED bank.
module alu_seq_ctrl #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = 3
) (
  input  logic           clk,
  input  logic           i_rst_n,
  alu_seq_ctrl_if.slave  bus
);

  localparam logic [NB_OP-1:0] LP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] LP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] LP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] LP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] LP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] LP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] LP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] LP_SRL = NB_OP'(6'b000010);
  localparam int               LP_MSB = NB_DATA - 1;
  localparam logic [NB_DATA:0] LP_NB_DATA = (NB_DATA + 1)'(NB_DATA);

  typedef enum logic [1:0] {
    ST_A    = 2'd0,
    ST_B    = 2'd1,
    ST_OP   = 2'd2,
    ST_EXEC = 2'd3
  } state_t;

  // Button bit order is {op, b, a}.
  logic [2:0]         w_btn;
  logic [2:0]         r_s0;
  logic [2:0]         r_s1;
  logic [2:0]         r_s2;
  logic [2:0]         r_pulse;

  state_t             r_state;
  state_t             w_next;
  logic               w_ld_a;
  logic               w_ld_b;
  logic               w_ld_op;
  logic               w_exec;

  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_err;
  logic               r_valid;

  logic [NB_DATA:0]    w_sum;
  logic [NB_DATA-1:0]  w_res;
  logic                w_carry;
  logic                w_ovf;
  logic                w_err;
  logic                w_zero;
  logic                w_big;
  logic [NB_SHAMT-1:0] w_shamt;

  assign w_btn = {bus.i_btn_op, bus.i_btn_b, bus.i_btn_a};

  // Two-FF synchroniser, then a third FF for edge detection, then a
  // registered one-cycle pulse. A held button yields a single pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0    <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_pulse <= '0;
    end else begin
      r_s0    <= w_btn;
      r_s1    <= r_s0;
      r_s2    <= r_s1;
      r_pulse <= r_s1 & ~r_s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_A;
    else          r_state <= w_next;
  end

  // Next state and load strobes. Only the pulse that matches the current
  // state acts. All other pulses are dropped.
  always_comb begin
    w_next  = r_state;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_ld_op = 1'b0;
    w_exec  = 1'b0;
    case (r_state)
      ST_A:    if (r_pulse[0]) begin w_ld_a  = 1'b1; w_next = ST_B;    end
      ST_B:    if (r_pulse[1]) begin w_ld_b  = 1'b1; w_next = ST_OP;   end
      ST_OP:   if (r_pulse[2]) begin w_ld_op = 1'b1; w_next = ST_EXEC; end
      ST_EXEC: begin w_exec = 1'b1; w_next = ST_A; end
      default: w_next = ST_A;
    endcase
  end

  // Shift amounts at or beyond the data width saturate.
  assign w_big   = ({1'b0, r_b} >= LP_NB_DATA);
  assign w_shamt = r_b[NB_SHAMT-1:0];

  // ALU datapath on the loaded operands.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (r_op)
      LP_ADD: begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_res   = w_sum[NB_DATA-1:0];
        w_carry = w_sum[NB_DATA];
        w_ovf   = (r_a[LP_MSB] == r_b[LP_MSB]) && (w_res[LP_MSB] != r_a[LP_MSB]);
      end
      LP_SUB: begin
        // Bit NB_DATA of the difference is the borrow (A < B unsigned).
        w_sum   = {1'b0, r_a} - {1'b0, r_b};
        w_res   = w_sum[NB_DATA-1:0];
        w_carry = w_sum[NB_DATA];
        w_ovf   = (r_a[LP_MSB] != r_b[LP_MSB]) && (w_res[LP_MSB] != r_a[LP_MSB]);
      end
      LP_AND: w_res = r_a & r_b;
      LP_OR:  w_res = r_a | r_b;
      LP_XOR: w_res = r_a ^ r_b;
      LP_NOR: w_res = ~(r_a | r_b);
      LP_SRA: begin
        if (w_big) w_res = {NB_DATA{r_a[LP_MSB]}};
        else       w_res = $signed(r_a) >>> w_shamt;
      end
      LP_SRL: begin
        if (w_big) w_res = '0;
        else       w_res = r_a >> w_shamt;
      end
      default: w_err = 1'b1;
    endcase
    w_zero = ~w_err & (w_res == '0);
  end

  // Operand and opcode loads. The result and flags are captured on the
  // execute cycle and held until the next execute. Valid drops when A loads.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_ld_a) begin
        r_a     <= bus.i_dato;
        r_valid <= 1'b0;
      end
      if (w_ld_b)  r_b  <= bus.i_dato;
      if (w_ld_op) r_op <= bus.i_dato[NB_OP-1:0];
      if (w_exec) begin
        r_result <= w_res;
        r_zero   <= w_zero;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
        r_err    <= w_err;
        r_valid  <= 1'b1;
      end
    end
  end

  assign bus.o_result   = r_result;
  assign bus.o_zero     = r_zero;
  assign bus.o_carry    = r_carry;
  assign bus.o_overflow = r_ovf;
  assign bus.o_err      = r_err;
  assign bus.o_valid    = r_valid;
  assign bus.o_state    = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. Expected results are queued when an
// operation is started. They are compared when the execute cycle closes.
module tb_alu_seq_ctrl;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  // clock / reset
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.NB_DATA(8)) bus ();

  alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6), .NB_SHAMT(3)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // scoreboard: {err, ovf, carry, zero, result}
  logic [11:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  last_res = 8'h00;

  function automatic logic [11:0] observed();
    return {bus.o_err, bus.o_overflow, bus.o_carry, bus.o_zero, bus.o_result};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] res, input logic z, input logic c,
                          input logic v, input logic e);
    exp_q.push_back({e, v, c, z, res});
  endtask

  // driver: which 0=a 1=b 2=op; held for 'hold' cycles, then released long
  // enough for the synchroniser to clear
  task automatic press(input int which, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.i_dato = d;
    case (which)
      0:       bus.i_btn_a  = 1'b1;
      1:       bus.i_btn_b  = 1'b1;
      default: bus.i_btn_op = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b, input int hold_a);
    press(0, a, hold_a);
    chk("state_after_a", 16'(bus.o_state), 16'd1);
    chk("valid_cleared_by_a", 16'(bus.o_valid), 16'd0);
    chk("result_held_after_a", 16'(bus.o_result), 16'(last_res));
    press(1, b, 4);
    chk("state_after_b", 16'(bus.o_state), 16'd2);
  endtask

  // Edge-counted opcode press: edges 1-3 make the pulse and edge 4 enters
  // execute. Edge 5 registers the result.
  task automatic exec_op(input logic [5:0] op);
    logic [11:0] e;
    @(negedge clk);
    bus.i_dato   = {2'b00, op};
    bus.i_btn_op = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("state_exec", 16'(bus.o_state), 16'd3);
    chk("valid_low_in_exec", 16'(bus.o_valid), 16'd0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underrun", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk("result_flags", 16'(observed()), 16'(e));
      last_res = e[7:0];
    end
    chk("valid_after_exec", 16'(bus.o_valid), 16'd1);
    chk("state_after_exec", 16'(bus.o_state), 16'd0);
    @(negedge clk);
    bus.i_btn_op = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int hold_a, input logic [7:0] res, input logic z,
                        input logic c, input logic v, input logic e);
    push_exp(res, z, c, v, e);
    load_ab(a, b, hold_a);
    exec_op(op);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] rsum;
    logic       rovf;

    bus.i_dato   = 8'h00;
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 16'(observed()), 16'd0);
    chk("reset_valid", 16'(bus.o_valid), 16'd0);
    chk("reset_state", 16'(bus.o_state), 16'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // arithmetic
    run_op(8'h7F, 8'h01, OP_ADD, 4, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, OP_SUB, 4, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h05, 8'h05, OP_SUB, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, OP_ADD, 4, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, OP_SUB, 4, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);

    // shifts, including saturation at B >= 8
    run_op(8'h80, 8'h03, OP_SRA, 4, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h09, OP_SRA, 4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h09, OP_SRL, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'h03, OP_SRL, 4, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    // logic ops
    run_op(8'hF0, 8'h0F, OP_OR,  4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h0F, OP_XOR, 4, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, OP_NOR, 4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // out-of-order buttons in ST_A are ignored and the outputs stay held
    press(1, 8'h55, 4);
    chk("ignore_b_in_a", 16'(bus.o_state), 16'd0);
    press(2, 8'h20, 4);
    chk("ignore_op_in_a", 16'(bus.o_state), 16'd0);
    chk("ignore_valid_held", 16'(bus.o_valid), 16'd1);
    chk("ignore_result_held", 16'(bus.o_result), 16'(last_res));

    // long hold on A, then an unsupported opcode
    run_op(8'h12, 8'h34, 6'h3F, 50, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8'hF0, 8'h3C, OP_AND, 4, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // A and B pressed together in ST_A: only A acts
    @(negedge clk);
    bus.i_dato  = 8'h05;
    bus.i_btn_a = 1'b1;
    bus.i_btn_b = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_btn_a = 1'b0;
    bus.i_btn_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("simul_ab_state", 16'(bus.o_state), 16'd1);
    press(1, 8'h02, 4);
    chk("simul_then_b_state", 16'(bus.o_state), 16'd2);
    push_exp(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    exec_op(OP_ADD);

    // asynchronous reset while in ST_OP
    load_ab(8'h11, 8'h22, 4);
    @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 16'(observed()), 16'd0);
    chk("async_reset_valid", 16'(bus.o_valid), 16'd0);
    chk("async_reset_state", 16'(bus.o_state), 16'd0);
    @(negedge clk);
    i_rst_n  = 1'b1;
    last_res = 8'h00;
    repeat (2) @(negedge clk);
    run_op(8'h10, 8'h20, OP_ADD, 4, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    // random additions
    for (int i = 0; i < 4; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rsum = {1'b0, ra} + {1'b0, rb};
      rovf = (ra[7] == rb[7]) && (rsum[7] != ra[7]);
      run_op(ra, rb, OP_ADD, 4, rsum[7:0], (rsum[7:0] == 8'h00), rsum[8], rovf, 1'b0);
    end

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
